tile_ram_loader: RTL
====================

Name: tile_ram_loader

Overview:
- Write-side counterpart of the tile-RAM read path in the pixel pipeline.
- Accepts a byte stream of RGB pixels, or a constant fill colour, and writes 32-bit pixel words into the single-port tile RAM. The word format is the one the pixel path reads back.
- Sits between the asset source (UART/SD byte stream) and the RAM's write port; runs in the clk_vga domain.
- Loads one TILE_W x TILE_H tile per command at a selectable tile slot.

Parameters:
- TILE_W, 50, tile width in pixels
- TILE_H, 50, tile height in pixels
- NUM_TILES, 8, number of tile slots in RAM
- ADDR_WIDTH, 16, RAM address width

Ports:
- clk_vga  in  1  clock, same clock as the video pipeline
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle command strobe
- fill_mode  in  1  sampled with start: 1 = constant fill, 0 = stream load
- tile_idx  in  3  sampled with start; destination slot, 0..NUM_TILES-1
- fill_color  in  24  sampled with start; {B,G,R}
- in_data  in  8  stream byte, order R, G, B per pixel, raster order
- in_valid  in  1  stream byte valid
- in_ready  out  1  loader accepts byte this cycle
- ram_address  out  ADDR_WIDTH  RAM write address
- ram_data  out  32  RAM write word
- ram_wren  out  1  RAM write enable
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on command completion
- cmd_err  out  1  one-cycle pulse when start is rejected for an out-of-range tile_idx

Behaviour:
- Reset values: in_ready=0, ram_wren=0, ram_address=0, ram_data=0, busy=0, done=0, cmd_err=0. Reset mid-command aborts immediately and returns to IDLE. The partial tile stays in RAM and no done is issued.
- Word format: ram_data = {8'h00, B, G, R}, so bits [7:0] are red, [15:8] green and [23:16] blue.
- Address: ram_address = tile_idx*TILE_W*TILE_H + pix. pix is the raster index 0..TILE_W*TILE_H-1 (y*TILE_W + x). The base is computed once at start, and the result is truncated to ADDR_WIDTH.
- States: IDLE, RECV, WRITE, FILL, DONE.
- IDLE:
  - start with tile_idx >= NUM_TILES: pulse cmd_err next cycle and stay in IDLE.
  - Otherwise, capture the command, clear pix and the byte counter, set busy=1, then go to FILL if fill_mode=1, else RECV.
- RECV:
  - in_ready=1; a byte is taken when in_valid && in_ready.
  - Byte counter 0→R, 1→G, 2→B.
  - On B accepted, go to WRITE.
  - in_valid low holds the state indefinitely; there is no timeout.
- WRITE:
  - in_ready=0; ram_wren=1 for exactly one cycle with the assembled word.
  - Then, if pix == TILE_W*TILE_H-1, go to DONE; else increment pix and return to RECV.
  - Throughput is 4 cycles per pixel when in_valid stays high.
- FILL:
  - ram_wren=1 every cycle with ram_data={8'h00, fill_color}, pix incrementing each cycle. No stream bytes are consumed (in_ready=0).
  - After writing pix == TILE_W*TILE_H-1, go to DONE. A fill takes exactly TILE_W*TILE_H write cycles.
- DONE: busy=0, done=1 for one cycle, then IDLE.
- busy is 1 from the cycle after an accepted start through the last write cycle.
- start while busy is ignored, with no error flag.
- ram_address, ram_data and ram_wren are registered outputs; ram_address and ram_data hold their last values while ram_wren=0.
- in_ready is combinational from state only, never from in_valid.

Test Plan:
- Reset then idle: all outputs 0 and in_ready=0 for 10 cycles with in_valid=1.
- Stream load, tile_idx=0, first bytes 0x11,0x22,0x33 with in_valid held high:
  - first write at address 0 with data 0x00332211; second pixel at address 1.
  - 2500 writes in total, last at address 2499, done pulses once, 10000 cycles after start.
- Fill, tile_idx=2, fill_color=0x0000FF:
  - 2500 consecutive ram_wren cycles at addresses 5000..7499, all with data 0x000000FF.
  - done follows the last write by one cycle; in_ready stays 0 throughout.
- Backpressure: toggle in_valid randomly during a stream load, and issue start mid-load with tile_idx=5.
  - Every byte handshake maps to the correct R/G/B lane.
  - The second start is ignored: the destination tile stays 0, and there is no cmd_err.
- Reject: start with tile_idx=7 and NUM_TILES=4 → cmd_err pulses once, busy stays 0, no writes.
- Mid-operation reset: assert reset after 100 pixels of a load, then start a fill on tile 1.
  - No done from the aborted load.
  - The fill starts at address 2500 with pix=0.

Source files
------------

// File: rtl/tile_ram_loader_if.sv
// Bundle of command, byte-stream and RAM write-port signals for tile_ram_loader.
//   master : command/stream source (drives start, fill_*, tile_idx, in_data, in_valid)
//   slave  : the loader (drives in_ready, ram_*, busy, done, cmd_err)
interface tile_ram_loader_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  // command, sampled with start
  logic                  start;
  logic                  fill_mode;
  logic [2:0]            tile_idx;
  logic [23:0]           fill_color;
  // RGB byte stream
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  // RAM write port
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [31:0]           ram_data;
  logic                  ram_wren;
  // status
  logic                  busy;
  logic                  done;
  logic                  cmd_err;

  modport master (
    output start, fill_mode, tile_idx, fill_color, in_data, in_valid,
    input  in_ready, ram_address, ram_data, ram_wren, busy, done, cmd_err
  );

  modport slave (
    input  start, fill_mode, tile_idx, fill_color, in_data, in_valid,
    output in_ready, ram_address, ram_data, ram_wren, busy, done, cmd_err
  );
endinterface

// File: rtl/tile_ram_loader.sv
// Tile RAM loader: writes one TILE_W x TILE_H tile of 32-bit pixel words
// ({8'h00, B, G, R}) into the tile RAM, either from an R,G,B byte stream or
// as a constant fill colour.
// Ports:
//   clk_vga  - pixel-pipeline clock
//   reset    - synchronous, active-high
//   bus      - tile_ram_loader_if.slave: command (start, fill_mode, tile_idx,
//              fill_color), stream (in_data, in_valid, in_ready), RAM write
//              port (ram_address, ram_data, ram_wren), status (busy, done,
//              cmd_err)
module tile_ram_loader #(
  parameter int unsigned TILE_W     = 50,
  parameter int unsigned TILE_H     = 50,
  parameter int unsigned NUM_TILES  = 8,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic            clk_vga,
  input  logic            reset,
  tile_ram_loader_if.slave bus
);

  localparam int unsigned TILE_PIX = TILE_W * TILE_H;
  localparam int unsigned PIX_W    = (TILE_PIX > 1) ? $clog2(TILE_PIX) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(TILE_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]            red_q, red_d;
  logic [7:0]            green_q, green_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [31:0]           ram_data_q, ram_data_d;
  logic                  ram_wren_q, ram_wren_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cmd_err_q, cmd_err_d;

  logic                  tile_ok;
  logic [ADDR_WIDTH-1:0] start_base;
  logic                  byte_take;

  // Command decode; the slot index is widened so the range check is a plain compare.
  assign tile_ok    = 32'(bus.tile_idx) < NUM_TILES;
  assign start_base = ADDR_WIDTH'(32'(bus.tile_idx) * TILE_PIX);
  assign byte_take  = bus.in_valid && (state_q == S_RECV);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    pix_d         = pix_q;
    byte_cnt_d    = byte_cnt_q;
    red_d         = red_q;
    green_d       = green_q;
    base_d        = base_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    cmd_err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (!tile_ok) begin
            cmd_err_d = 1'b1;
          end else begin
            base_d     = start_base;
            pix_d      = '0;
            byte_cnt_d = '0;
            busy_d     = 1'b1;
            if (bus.fill_mode) begin
              // First fill word goes out on the very next cycle.
              state_d       = S_FILL;
              ram_wren_d    = 1'b1;
              ram_address_d = start_base;
              ram_data_d    = {8'h00, bus.fill_color};
            end else begin
              state_d = S_RECV;
            end
          end
        end
      end

      S_RECV: begin
        if (byte_take) begin
          case (byte_cnt_q)
            2'd0: begin
              red_d      = bus.in_data;
              byte_cnt_d = 2'd1;
            end
            2'd1: begin
              green_d    = bus.in_data;
              byte_cnt_d = 2'd2;
            end
            default: begin
              // Blue byte completes the pixel; the word is written in S_WRITE.
              byte_cnt_d    = 2'd0;
              ram_wren_d    = 1'b1;
              ram_address_d = base_q + ADDR_WIDTH'(pix_q);
              ram_data_d    = {8'h00, bus.in_data, green_q, red_q};
              state_d       = S_WRITE;
            end
          endcase
        end
      end

      S_WRITE: begin
        if (pix_q == PIX_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          pix_d   = pix_q + PIX_W'(1);
          state_d = S_RECV;
        end
      end

      S_FILL: begin
        if (pix_q == PIX_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          pix_d         = pix_q + PIX_W'(1);
          ram_wren_d    = 1'b1;
          ram_address_d = ram_address_q + ADDR_WIDTH'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pix_q         <= '0;
      byte_cnt_q    <= '0;
      red_q         <= '0;
      green_q       <= '0;
      base_q        <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_q         <= pix_d;
      byte_cnt_q    <= byte_cnt_d;
      red_q         <= red_d;
      green_q       <= green_d;
      base_q        <= base_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  // in_ready depends on state only so the source never sees a valid->ready loop.
  assign bus.in_ready    = (state_q == S_RECV);
  assign bus.ram_address = ram_address_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.ram_wren    = ram_wren_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cmd_err     = cmd_err_q;

endmodule
